// File: rtl/vs_vertex_assembler_pkg.sv
// vs_vertex_assembler_pkg: shared widths, slot state encoding and vertex payload type
package vs_vertex_assembler_pkg;
    localparam int DW    = 32;
    localparam int NCOMP = 4;
    localparam int IDW   = 8;
    localparam int CW    = $clog2(NCOMP);
    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;
    typedef struct packed {
        logic [NCOMP*DW-1:0] data;
        logic [IDW-1:0]      id;
        logic                eob;
    } vtx_t;
endpackage

// File: rtl/vs_vertex_assembler_if.sv
// vs_vertex_assembler_if: attribute word stream in, assembled vertex stream out
//   master: drives in_valid/in_data/in_last and vtx_ready
//   slave : drives in_ready and vtx_valid/vtx_data/vtx_id/vtx_eob/err_short
interface vs_vertex_assembler_if;
    import vs_vertex_assembler_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic                in_last;
    logic                vtx_valid;
    logic                vtx_ready;
    logic [NCOMP*DW-1:0] vtx_data;
    logic [IDW-1:0]      vtx_id;
    logic                vtx_eob;
    logic                err_short;
    modport master(output in_valid, in_data, in_last, vtx_ready,
                   input in_ready, vtx_valid, vtx_data, vtx_id, vtx_eob, err_short);
    modport slave(input in_valid, in_data, in_last, vtx_ready,
                  output in_ready, vtx_valid, vtx_data, vtx_id, vtx_eob, err_short);
endinterface

// File: rtl/vs_vtx_slot.sv
// vs_vtx_slot: one-entry valid/ready holding register for assembled vertices
//   clk, resetn (sync, active-low); load/din write the entry;
//   out_valid/out_ready/dout form the downstream handshake
module vs_vtx_slot
    import vs_vertex_assembler_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  vtx_t din,
    input  logic out_ready,
    output logic out_valid,
    output vtx_t dout
);
    slot_e state_q, state_d;
    vtx_t  dout_q, dout_d;

    // A load while FULL only happens alongside a handshake, so replacing is lossless
    always_comb begin
        state_d = load ? SLOT_FULL : (state_q == SLOT_FULL && out_ready) ? SLOT_EMPTY : state_q;
        dout_d  = load ? din : dout_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SLOT_EMPTY;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
        end
    end

    assign out_valid = state_q == SLOT_FULL;
    assign dout      = dout_q;
endmodule

// File: rtl/vs_vertex_assembler.sv
// vs_vertex_assembler: packs attribute words into NCOMP-component vertices
//   clk, resetn (sync, active-low); bus.slave carries the word input stream,
//   the vertex output slot and the err_short pulse
module vs_vertex_assembler
    import vs_vertex_assembler_pkg::*;
(
    input logic                 clk,
    input logic                 resetn,
    vs_vertex_assembler_if.slave bus
);
    logic [CW-1:0]              comp_cnt_q, comp_cnt_d;
    logic [IDW-1:0]             id_cnt_q, id_cnt_d;
    logic [NCOMP-2:0][DW-1:0]   stage_q, stage_d;
    logic                       err_short_q, err_short_d;
    logic                       accept, complete, last_comp;
    vtx_t                       vtx_new, vtx_out;

    assign bus.in_ready = resetn & (~bus.vtx_valid | bus.vtx_ready);

    // Staging entries at or above comp_cnt are always zero, so the vertex is
    // the staging regs with the current word dropped into slot comp_cnt
    always_comb begin
        accept       = bus.in_valid & bus.in_ready;
        last_comp    = comp_cnt_q == CW'(NCOMP - 1);
        complete     = accept & (last_comp | bus.in_last);
        vtx_new.data = '0;
        stage_d      = stage_q;
        for (int i = 0; i < NCOMP - 1; i++) begin
            vtx_new.data[i*DW +: DW] = comp_cnt_q == CW'(i) ? bus.in_data : stage_q[i];
            stage_d[i] = complete ? '0 : (accept && comp_cnt_q == CW'(i)) ? bus.in_data : stage_q[i];
        end
        vtx_new.data[(NCOMP-1)*DW +: DW] = last_comp ? bus.in_data : '0;
        vtx_new.id   = id_cnt_q;
        vtx_new.eob  = bus.in_last;
        comp_cnt_d   = complete ? '0 : accept ? comp_cnt_q + CW'(1) : comp_cnt_q;
        id_cnt_d     = complete ? (bus.in_last ? '0 : id_cnt_q + IDW'(1)) : id_cnt_q;
        err_short_d  = complete & bus.in_last & ~last_comp;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            comp_cnt_q  <= '0;
            id_cnt_q    <= '0;
            stage_q     <= '0;
            err_short_q <= 1'b0;
        end else begin
            comp_cnt_q  <= comp_cnt_d;
            id_cnt_q    <= id_cnt_d;
            stage_q     <= stage_d;
            err_short_q <= err_short_d;
        end
    end

    vs_vtx_slot u_slot (
        .clk       (clk),
        .resetn    (resetn),
        .load      (complete),
        .din       (vtx_new),
        .out_ready (bus.vtx_ready),
        .out_valid (bus.vtx_valid),
        .dout      (vtx_out)
    );

    assign bus.vtx_data  = vtx_out.data;
    assign bus.vtx_id    = vtx_out.id;
    assign bus.vtx_eob   = vtx_out.eob;
    assign bus.err_short = err_short_q;
endmodule
